// File: rtl/seg_pkg.sv
// Shared types and constants for the four-digit 7-segment scan driver.
package seg_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int SEG_W      = 7;

  // One segment pattern, bit set = segment lit (internal polarity).
  typedef logic [SEG_W-1:0] seg_t;

  // BLANK keeps every digit dark at the start of a slot; SHOW drives digit idx.
  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

endpackage

// File: rtl/scan_prescaler.sv
// Slot prescaler: counts 0..DIV-1 and flags the last cycle of every slot.
module scan_prescaler #(
  parameter  int DIV   = 50000,
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] cnt,
  output logic             slot_tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  // Free-running slot counter, wrapping after the last cycle of the slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt       = r_cnt;
  assign slot_tick = (r_cnt == LAST);

endmodule

// File: rtl/seg_scan.sv
// Four-digit multiplexed 7-segment driver with per-digit shadow registers
// and a blanking gap at the start of every digit slot.
module seg_scan
  import seg_pkg::*;
#(
  parameter int DIV            = 50000,
  parameter int BLANK_CYCLES   = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [1:0]            wr_adr,
  input  seg_t                  data0,
  input  seg_t                  data1,
  input  seg_t                  data2,
  input  seg_t                  data3,
  output seg_t                  seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  slot_tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] BLANK_END =
    CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  // Every slot opens in BLANK unless there is no blanking gap at all.
  localparam scan_state_t SLOT_START = (BLANK_CYCLES > 0) ? BLANK : SHOW;
  // XOR masks: the "all dark" value on each bus is exactly its mask.
  localparam seg_t SEG_MASK = SEG_ACTIVE_LOW ? '1 : '0;
  localparam logic [NUM_DIGITS-1:0] AN_MASK = AN_ACTIVE_LOW ? '1 : '0;

  logic [CNT_W-1:0]      w_cnt;
  logic                  w_slotTick;
  seg_t                  w_wrData;
  seg_t                  r_dig [NUM_DIGITS];
  logic [1:0]            r_idx;
  scan_state_t           r_state;
  scan_state_t           w_nextState;
  seg_t                  w_segLit;
  logic [NUM_DIGITS-1:0] w_anOn;
  seg_t                  r_seg;
  logic [NUM_DIGITS-1:0] r_an;

  scan_prescaler #(.DIV(DIV)) u_prescaler (
    .clk       (clk),
    .rst_n     (rst_n),
    .cnt       (w_cnt),
    .slot_tick (w_slotTick)
  );

  // Pick the demux output that belongs to the addressed digit.
  always_comb begin
    w_wrData = data0;
    case (wr_adr)
      2'd0:    w_wrData = data0;
      2'd1:    w_wrData = data1;
      2'd2:    w_wrData = data2;
      default: w_wrData = data3;
    endcase
  end

  // Shadow registers: only the addressed digit is overwritten on a strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) r_dig[i] <= '0;
    end else if (wr_en) begin
      r_dig[wr_adr] <= w_wrData;
    end
  end

  // Digit index steps once per slot and wraps naturally at 2 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= 2'd0;
    end else if (w_slotTick) begin
      r_idx <= r_idx + 2'd1;
    end
  end

  // Scan state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SLOT_START;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state: restart the slot on the tick, leave BLANK once the gap ends.
  always_comb begin
    w_nextState = r_state;
    if (w_slotTick) begin
      w_nextState = SLOT_START;
    end else if (r_state == BLANK && w_cnt == BLANK_END) begin
      w_nextState = SHOW;
    end
  end

  // Active-high view of what the buses should carry for the current cycle.
  always_comb begin
    w_segLit = '0;
    w_anOn   = '0;
    if (r_state == SHOW) begin
      w_segLit       = r_dig[r_idx];
      w_anOn[r_idx]  = 1'b1;
    end
  end

  // Output registers; board polarity is applied only here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= SEG_MASK;
      r_an  <= AN_MASK;
    end else begin
      r_seg <= w_segLit ^ SEG_MASK;
      r_an  <= w_anOn ^ AN_MASK;
    end
  end

  assign seg       = r_seg;
  assign an        = r_an;
  assign slot_tick = w_slotTick;

endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan: two instances (8/2 active-low, 4/0 active-high) share
// one stimulus stream and are checked every cycle against a time-based model.
module tb_seg_scan;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_adr = 2'd0;
  logic [6:0] data [4];

  logic [6:0] segA, segB;
  logic [3:0] anA, anB;
  logic       tickA, tickB;

  int passCount = 0;
  int checkCount = 0;
  bit checking = 1'b0;

  // Model state: cycle index since reset release and the digit contents.
  int         cyc = 0;
  logic [6:0] mdig [4];
  logic [6:0] expSegA = 7'h7F, expSegB = 7'h00;
  logic [3:0] expAnA = 4'hF, expAnB = 4'h0;

  seg_scan #(.DIV(8), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dutA (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_adr(wr_adr),
    .data0(data[0]), .data1(data[1]), .data2(data[2]), .data3(data[3]),
    .seg(segA), .an(anA), .slot_tick(tickA)
  );

  seg_scan #(.DIV(4), .BLANK_CYCLES(0), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)) dutB (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_adr(wr_adr),
    .data0(data[0]), .data1(data[1]), .data2(data[2]), .data3(data[3]),
    .seg(segB), .an(anB), .slot_tick(tickB)
  );

  always #5 clk = ~clk;

  // Segment bus during cycle c: lit pattern of digit (c/div)%4 once past the gap.
  function automatic logic [6:0] modelSeg(int div, int blank, bit activeLow, int c, logic [6:0] digit);
    logic [6:0] v;
    v = ((c % div) >= blank) ? digit : 7'h00;
    return activeLow ? ~v : v;
  endfunction

  function automatic logic [3:0] modelAn(int div, int blank, bit activeLow, int c);
    logic [3:0] v;
    v = ((c % div) >= blank) ? (4'b0001 << ((c / div) % 4)) : 4'b0000;
    return activeLow ? ~v : v;
  endfunction

  // Model update: outputs registered at this edge reflect the cycle just ended.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc <= 0;
      for (int i = 0; i < 4; i++) mdig[i] <= 7'h00;
      expSegA <= 7'h7F;
      expAnA  <= 4'hF;
      expSegB <= 7'h00;
      expAnB  <= 4'h0;
    end else begin
      expSegA <= modelSeg(8, 2, 1'b1, cyc, mdig[(cyc / 8) % 4]);
      expAnA  <= modelAn(8, 2, 1'b1, cyc);
      expSegB <= modelSeg(4, 0, 1'b0, cyc, mdig[(cyc / 4) % 4]);
      expAnB  <= modelAn(4, 0, 1'b0, cyc);
      if (wr_en) mdig[wr_adr] <= data[wr_adr];
      cyc <= cyc + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      passCount++;
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (checking) begin
      checkOutput("segA", 32'(segA), 32'(expSegA));
      checkOutput("anA", 32'(anA), 32'(expAnA));
      checkOutput("tickA", 32'(tickA), 32'(rst_n && (cyc % 8 == 7)));
      checkOutput("segB", 32'(segB), 32'(expSegB));
      checkOutput("anB", 32'(anB), 32'(expAnB));
      checkOutput("tickB", 32'(tickB), 32'(rst_n && (cyc % 4 == 3)));
    end
  end

  // Drive one write strobe for a single cycle, other data inputs random.
  task automatic applyStimulus(input logic [1:0] adr, input logic [6:0] value);
    for (int i = 0; i < 4; i++) data[i] = 7'($urandom);
    wr_en  = 1'b1;
    wr_adr = adr;
    data[adr] = value;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Wait (bounded) until the current cycle index hits a phase of the frame.
  task automatic waitPhase(input int period, input int target);
    int n;
    n = 0;
    while ((cyc % period) != target && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("waitPhase", 32'(cyc % period), 32'(target));
  endtask

  logic [6:0] pat [4];

  initial begin
    for (int i = 0; i < 4; i++) data[i] = 7'h00;
    pat[0] = 7'h3F; pat[1] = 7'h06; pat[2] = 7'h5B; pat[3] = 7'h4F;

    // Reset held: all buses dark.
    repeat (3) @(negedge clk);
    checkOutput("rstSegA", 32'(segA), 32'h7F);
    checkOutput("rstAnA", 32'(anA), 32'hF);
    checkOutput("rstSegB", 32'(segB), 32'h00);
    checkOutput("rstAnB", 32'(anB), 32'h0);
    checking = 1'b1;

    // Release: digit 0 first enabled after edge 3 on A, edge 1 on B.
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("firstAnB", 32'(anB), 32'h1);
    @(negedge clk);
    checkOutput("stillBlankA", 32'(anA), 32'hF);
    @(negedge clk);
    checkOutput("firstAnA", 32'(anA), 32'hE);
    checkOutput("firstSegA", 32'(segA), 32'h7F);

    // Load all four digits, then walk one full frame of instance A.
    for (int d = 0; d < 4; d++) applyStimulus(2'(d), pat[d]);
    waitPhase(32, 0);
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if ((k % 8) >= 2) begin
        checkOutput("walkAn", 32'(anA), 32'(~(4'b0001 << (k / 8)) & 4'hF));
        checkOutput("walkSeg", 32'(segA), 32'(~pat[k / 8] & 7'h7F));
      end else begin
        checkOutput("walkGapAn", 32'(anA), 32'hF);
        checkOutput("walkGapSeg", 32'(segA), 32'h7F);
      end
    end

    // Randomised writes while scanning.
    for (int n = 0; n < 600; n++) begin
      wr_en  = ($urandom_range(0, 3) == 0);
      wr_adr = 2'($urandom);
      for (int i = 0; i < 4; i++) data[i] = 7'($urandom);
      @(negedge clk);
    end
    wr_en = 1'b0;

    // Write to the digit currently shown: visible two edges after the strobe.
    waitPhase(32, 19);
    applyStimulus(2'd2, 7'h7F);
    @(negedge clk);
    checkOutput("liveWriteSeg", 32'(segA), 32'h00);
    checkOutput("liveWriteAn", 32'(anA), 32'hB);

    // Write landing on the slot tick of digit 0 feeds digit 1's SHOW.
    waitPhase(32, 7);
    checkOutput("tickAtPhase7", 32'(tickA), 32'h1);
    applyStimulus(2'd1, 7'h77);
    waitPhase(32, 12);
    checkOutput("tickWriteSeg", 32'(segA), 32'h08);
    checkOutput("tickWriteAn", 32'(anA), 32'hD);

    // Asynchronous reset in the middle of digit 3's SHOW.
    waitPhase(32, 28);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("asyncSegA", 32'(segA), 32'h7F);
    checkOutput("asyncAnA", 32'(anA), 32'hF);
    checkOutput("asyncSegB", 32'(segB), 32'h00);
    checkOutput("asyncAnB", 32'(anB), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("restartAn", 32'(anA), 32'hE);
    checkOutput("restartSeg", 32'(segA), 32'h7F);
    waitPhase(32, 28);
    checkOutput("restartDig3An", 32'(anA), 32'h7);
    checkOutput("restartDig3Seg", 32'(segA), 32'h7F);
    repeat (8) @(negedge clk);

    checking = 1'b0;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/seg_scan.md
# seg_scan

Time-multiplexed four-digit 7-segment scan driver sitting directly downstream of the coder/demux stage. Latches each demultiplexed segment pattern into a per-digit shadow register on a write strobe, then cycles through the four digits, driving one shared segment bus and four digit-enable lines. Inserts a programmable blanking gap between digits to suppress ghosting.

## Interface
- DIV, 50000: clock cycles per digit slot; must satisfy DIV >= 2.
- BLANK_CYCLES, 4: blank cycles at the start of each slot; must satisfy 0 <= BLANK_CYCLES < DIV.
- SEG_ACTIVE_LOW, 1: 1 = a lit segment drives 0 on `seg`.
- AN_ACTIVE_LOW, 1: 1 = the enabled digit drives 0 on `an`.

- clk  in  1  system clock.
- rst_n  in  1  reset; one clock, reset asynchronous and active-low.
- wr_en  in  1  write strobe; latch the addressed digit this cycle.
- wr_adr  in  2  digit address for the write; same address that fed the demux.
- data0..data3  in  7 each  demux outputs; internal polarity is 1 = segment lit.
- seg  out  7  shared segment bus, registered, polarity set by SEG_ACTIVE_LOW.
- an  out  4  digit enables, one-hot when active, registered, polarity set by AN_ACTIVE_LOW; bit i is digit i.
- slot_tick  out  1  one-cycle pulse on the last cycle of every slot.

## Operation
- Shadow registers dig[0..3], 7 bits each, reset to 0.
- When wr_en = 1: dig[wr_adr] <= data{wr_adr}. Other digits and other data inputs are ignored.
- Prescaler cnt runs 0..DIV-1 and wraps. It is $clog2(DIV) bits wide. slot_tick = (cnt == DIV-1).
- Digit index idx is 2 bits. It increments on slot_tick and wraps 3 -> 0.
- FSM has two states, BLANK and SHOW.
  - BLANK: an is all inactive and seg is all unlit. Move to SHOW when cnt == BLANK_CYCLES-1. If BLANK_CYCLES = 0, BLANK is never entered and every slot is SHOW.
  - SHOW: an enables digit idx and seg = dig[idx]. A write to the displayed digit is visible within the same slot.
  - On slot_tick, from either state: go to BLANK if BLANK_CYCLES > 0, else stay in SHOW. idx advances.
- Polarity is applied only at the output registers. Internal logic is active-high.
- Reset mid-operation: all state returns to reset values immediately, asynchronously. Shadow contents are lost.

## Timing
- Reset values:
  - seg = all unlit (7'h7F if SEG_ACTIVE_LOW, else 0).
  - an = all inactive (4'hF if AN_ACTIVE_LOW, else 0).
  - slot_tick = 0, cnt = 0, idx = 0.
  - state = BLANK, or SHOW if BLANK_CYCLES = 0.
- Outputs are registered. seg and an reflect the state and idx of the previous cycle, giving one cycle of latency.
- Write latency: wr_en is sampled at edge k and dig is updated at edge k. If that digit is in SHOW, seg shows the new value after edge k+1.
- Slot length is exactly DIV cycles. A full frame is 4*DIV cycles.
- Lit time per digit is DIV-BLANK_CYCLES cycles.
- First lit cycle after reset release: an shows digit 0 after edge BLANK_CYCLES+1.
- slot_tick is combinational from cnt: high for 1 cycle, every DIV cycles.
- Simultaneous write and slot_tick: the write completes, and the next digit's SHOW uses the updated dig.
- At most one digit enable is active in any cycle. During BLANK, zero enables are active.

## Structure
- Package seg_pkg holds:
  - typedef seg_t (7-bit logic).
  - enum scan_state_t {BLANK, SHOW}.
  - constants NUM_DIGITS = 4 and SEG_W = 7.
- Sub-module scan_prescaler has parameter DIV, ports clk/rst_n, and outputs cnt and slot_tick.
- seg_scan instantiates scan_prescaler and contains the shadow registers, idx, the FSM, and the output registers.

## Test plan
- Reset check (DIV = 8, BLANK_CYCLES = 2, active-low): hold rst_n = 0 -> seg = 7'h7F, an = 4'hF. Release -> an = 4'b1110 first appears after edge 3, and seg = 7'h7F while dig0 is 0.
- Write all digits: write 7'h3F/0x06/0x5B/0x4F to adr 0..3 -> over one frame (32 cycles), an walks 1110, 1101, 1011, 0111. seg shows ~0x3F, ~0x06, ~0x5B, ~0x4F, each lit for 6 cycles with 2 blank cycles before it.
- Write to displayed digit: while in SHOW of digit 2, write 7'h7F to adr 2 -> seg = 7'h00 exactly 2 edges after the strobe edge. Other digits are unchanged in the next frame.
- Write coincident with slot_tick: write 7'h77 to adr 1 on the slot_tick cycle of digit 0 -> digit 1's SHOW displays ~0x77.
- BLANK_CYCLES = 0, DIV = 4: an is never all-inactive after reset, and switches digit every 4 cycles.
- Mid-frame reset: assert rst_n = 0 during SHOW of digit 3 -> outputs go to reset values without waiting for clk. After release, the scan restarts at digit 0 with all digits blank.
